// File: rtl/pagerank_reducer.sv
// Per-node rank accumulator for one pageRank iteration. The rank vector is written
// back to memory one node at a time, and the accumulators are cleared once the
// scheduler consumes the completion.
module pagerank_reducer #(
   parameter  int nbits     = 32,
   parameter  int nnodes    = 8,
   parameter  int ibits     = 3,
   localparam int len_bits  = $clog2(nbits / 8),
   localparam int req_bits  = 3 + 8 + 32 + len_bits + nbits,
   localparam int resp_bits = 3 + 8 + len_bits + nbits
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_val,
   output logic                 in_rdy,
   input  logic [ibits-1:0]     in_idx,
   input  logic [nbits-1:0]     in_data,
   input  logic                 go_val,
   output logic                 go_rdy,
   input  logic [31:0]          go_base,
   output logic                 done_val,
   input  logic                 done_rdy,
   output logic [31:0]          done_count,
   output logic [req_bits-1:0]  mem_req_msg,
   output logic                 mem_req_val,
   input  logic                 mem_req_rdy,
   input  logic [resp_bits-1:0] mem_resp_msg,
   input  logic                 mem_resp_val,
   output logic                 mem_resp_rdy
);

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      WREQ  = 2'd1,
      WRESP = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state_reg, state_next;
   logic [ibits-1:0]    ptr_reg, ptr_next;
   logic [31:0]         base_reg, base_next;
   logic [31:0]         count_reg, count_next;
   logic [nbits-1:0]    acc_reg [nnodes];
   logic                clear_acc;
   logic                in_fire;
   logic                in_range;

   // Response payload is deliberately ignored; only the handshake matters.
   logic unused_resp_bits;
   assign unused_resp_bits = ^mem_resp_msg;

   assign in_fire  = in_val && in_rdy;
   assign in_range = (32'(in_idx) < nnodes);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ACCUM;
         ptr_reg   <= '0;
         base_reg  <= '0;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         base_reg  <= base_next;
         count_reg <= count_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      ptr_next     = ptr_reg;
      base_next    = base_reg;
      count_next   = count_reg;
      in_rdy       = 1'b0;
      go_rdy       = 1'b0;
      mem_req_val  = 1'b0;
      mem_resp_rdy = 1'b0;
      done_val     = 1'b0;
      clear_acc    = 1'b0;
      case (state_reg)
         ACCUM: begin
            in_rdy = 1'b1;
            go_rdy = 1'b1;
            // A contribution arriving with go is counted before write-back starts.
            if (in_fire && in_range)
               count_next = count_reg + 32'd1;
            if (go_val) begin
               base_next  = go_base;
               ptr_next   = '0;
               state_next = WREQ;
            end
         end
         WREQ: begin
            mem_req_val = 1'b1;
            if (mem_req_rdy)
               state_next = WRESP;
         end
         WRESP: begin
            mem_resp_rdy = 1'b1;
            if (mem_resp_val) begin
               if (ptr_reg == ibits'(nnodes - 1)) begin
                  state_next = DONE;
               end else begin
                  ptr_next   = ptr_reg + ibits'(1);
                  state_next = WREQ;
               end
            end
         end
         DONE: begin
            done_val = 1'b1;
            if (done_rdy) begin
               count_next = '0;
               clear_acc  = 1'b1;
               state_next = ACCUM;
            end
         end
         default: state_next = ACCUM;
      endcase
   end

   // One accumulator per node; indices at or beyond nnodes match none of them.
   generate
      for (genvar gi = 0; gi < nnodes; gi++) begin : g_acc
         always_ff @(posedge clk) begin
            if (reset || clear_acc)
               acc_reg[gi] <= '0;
            else if (in_fire && (in_idx == ibits'(gi)))
               acc_reg[gi] <= acc_reg[gi] + in_data;
         end
      end
   endgenerate

   assign done_count  = count_reg;
   assign mem_req_msg = {3'd1,
                         {{(8 - ibits){1'b0}}, ptr_reg},
                         base_reg + {{(30 - ibits){1'b0}}, ptr_reg, 2'b00},
                         {len_bits{1'b0}},
                         acc_reg[ptr_reg]};

endmodule

// File: tb/tb_pagerank_reducer.sv
// Scoreboard bench: unit 0 has 8 nodes, unit 1 has 6 nodes (exercises index drop).
// Stimulus pushes expected writes/completions; the monitor pops and compares on each fire.
module tb_pagerank_reducer;

   logic        clk = 1'b0;
   logic        reset        [2];
   logic        in_val       [2];
   logic        in_rdy       [2];
   logic [2:0]  in_idx       [2];
   logic [31:0] in_data      [2];
   logic        go_val       [2];
   logic        go_rdy       [2];
   logic [31:0] go_base      [2];
   logic        done_val     [2];
   logic        done_rdy     [2];
   logic [31:0] done_count   [2];
   logic [76:0] mem_req_msg  [2];
   logic        mem_req_val  [2];
   logic        mem_req_rdy  [2];
   logic [44:0] mem_resp_msg [2];
   logic        mem_resp_val [2];
   logic        mem_resp_rdy [2];

   bit          stall_en  [2];
   bit          resp_hold [2];
   logic [31:0] ea        [8];

   typedef struct {
      int          unit;
      bit          is_done;
      logic [76:0] msg;
      logic [31:0] cnt;
   } exp_t;

   typedef struct {
      string       name;
      logic [31:0] act;
      logic [31:0] exp;
   } chk_t;

   exp_t exp_q[$];
   chk_t chk_q[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   pagerank_reducer #(.nbits(32), .nnodes(8), .ibits(3)) u0 (
      .clk(clk), .reset(reset[0]),
      .in_val(in_val[0]), .in_rdy(in_rdy[0]), .in_idx(in_idx[0]), .in_data(in_data[0]),
      .go_val(go_val[0]), .go_rdy(go_rdy[0]), .go_base(go_base[0]),
      .done_val(done_val[0]), .done_rdy(done_rdy[0]), .done_count(done_count[0]),
      .mem_req_msg(mem_req_msg[0]), .mem_req_val(mem_req_val[0]), .mem_req_rdy(mem_req_rdy[0]),
      .mem_resp_msg(mem_resp_msg[0]), .mem_resp_val(mem_resp_val[0]), .mem_resp_rdy(mem_resp_rdy[0])
   );

   pagerank_reducer #(.nbits(32), .nnodes(6), .ibits(3)) u1 (
      .clk(clk), .reset(reset[1]),
      .in_val(in_val[1]), .in_rdy(in_rdy[1]), .in_idx(in_idx[1]), .in_data(in_data[1]),
      .go_val(go_val[1]), .go_rdy(go_rdy[1]), .go_base(go_base[1]),
      .done_val(done_val[1]), .done_rdy(done_rdy[1]), .done_count(done_count[1]),
      .mem_req_msg(mem_req_msg[1]), .mem_req_val(mem_req_val[1]), .mem_req_rdy(mem_req_rdy[1]),
      .mem_resp_msg(mem_resp_msg[1]), .mem_resp_val(mem_resp_val[1]), .mem_resp_rdy(mem_resp_rdy[1])
   );

   // Monitor: the only process that steps the counters.
   task automatic sb_check(input int u, input bit kind, input logic [76:0] msg, input logic [31:0] cnt);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL sb_unexpected u%0d: got kind=%0d msg=%h cnt=%0d required nothing", u, kind, msg, cnt);
      end else begin
         e = exp_q.pop_front();
         if (e.unit != u || e.is_done != kind || e.msg !== msg || e.cnt !== cnt) begin
            failures++;
            $display("FAIL sb_%s u%0d: got kind=%0d msg=%h cnt=%0d required u%0d kind=%0d msg=%h cnt=%0d",
                     kind ? "done" : "write", u, kind, msg, cnt, e.unit, e.is_done, e.msg, e.cnt);
         end else if (kind) begin
            $display("done  u%0d count=%0d", u, cnt);
         end else begin
            $display("write u%0d node=%0d addr=%h data=%h", u, msg[73:66], msg[65:34], msg[31:0]);
         end
      end
   endtask

   always @(negedge clk) begin
      chk_t d;
      while (chk_q.size() > 0) begin
         d = chk_q.pop_front();
         checks++;
         if (d.act !== d.exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", d.name, d.act, d.exp);
         end
      end
      for (int u = 0; u < 2; u++) begin
         if (reset[u] === 1'b0 && mem_req_val[u] && mem_req_rdy[u])
            sb_check(u, 1'b0, mem_req_msg[u], 32'd0);
         if (reset[u] === 1'b0 && done_val[u] && done_rdy[u])
            sb_check(u, 1'b1, 77'd0, done_count[u]);
      end
   end

   // Memory responder: one response per accepted write, optional random stalls.
   initial begin
      bit         rq   [2];
      bit         rs   [2];
      bit         pend [2];
      logic [7:0] op   [2];
      for (int u = 0; u < 2; u++) begin
         mem_req_rdy[u] = 1'b1; mem_resp_val[u] = 1'b0; mem_resp_msg[u] = '0;
         pend[u] = 1'b0; op[u] = '0;
      end
      forever begin
         @(negedge clk);
         for (int u = 0; u < 2; u++) begin
            rq[u] = mem_req_val[u] && mem_req_rdy[u];
            rs[u] = mem_resp_val[u] && mem_resp_rdy[u];
            if (rq[u]) op[u] = mem_req_msg[u][73:66];
         end
         @(posedge clk); #1;
         for (int u = 0; u < 2; u++) begin
            if (rs[u]) mem_resp_val[u] = 1'b0;
            if (rq[u]) pend[u] = 1'b1;
            if (reset[u]) begin
               pend[u] = 1'b0;
               mem_resp_val[u] = 1'b0;
            end else if (pend[u] && !mem_resp_val[u] && !resp_hold[u] &&
                         (!stall_en[u] || $urandom_range(0, 2) != 0)) begin
               mem_resp_val[u] = 1'b1;
               mem_resp_msg[u] = {3'd1, op[u], 2'd0, 32'd0};
               pend[u] = 1'b0;
            end
            mem_req_rdy[u] = !stall_en[u] || ($urandom_range(0, 1) == 1);
         end
      end
   end

   task automatic post(input string nm, input logic [31:0] a, input logic [31:0] e);
      chk_t c;
      c.name = nm; c.act = a; c.exp = e;
      chk_q.push_back(c);
   endtask

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic push_wr(input int u, input int node, input logic [31:0] addr, input logic [31:0] data);
      exp_t e;
      e.unit = u; e.is_done = 1'b0; e.cnt = 32'd0;
      e.msg = {3'd1, 8'(node), addr, 2'd0, data};
      exp_q.push_back(e);
   endtask

   task automatic send(input int u, input logic [2:0] idx, input logic [31:0] d);
      bit ok = 0;
      in_val[u] = 1'b1; in_idx[u] = idx; in_data[u] = d;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (in_rdy[u]) ok = 1;
         cyc();
      end
      in_val[u] = 1'b0;
      $display("send  u%0d idx=%0d data=%h accepted=%0d", u, idx, d, ok);
      if (!ok) post("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_reset(input int u);
      reset[u] = 1'b1; cyc(); cyc(); reset[u] = 1'b0;
   endtask

   // Issue go (optionally with a same-cycle contribution) and expect nn writes of ea[].
   task automatic run_go(input int u, input int nn, input logic [31:0] base, input logic [31:0] cnt,
                         input int hold, input bit with_in, input logic [2:0] idx, input logic [31:0] d);
      exp_t e;
      bit   ok = 0;
      bit   bad = 0;
      int   held = 0;
      for (int i = 0; i < nn; i++) push_wr(u, i, base + 32'(4 * i), ea[i]);
      e.unit = u; e.is_done = 1'b1; e.msg = '0; e.cnt = cnt;
      exp_q.push_back(e);
      go_val[u] = 1'b1; go_base[u] = base; done_rdy[u] = (hold == 0);
      if (with_in) begin
         in_val[u] = 1'b1; in_idx[u] = idx; in_data[u] = d;
      end
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (go_rdy[u]) ok = 1;
         cyc();
      end
      go_val[u] = 1'b0; in_val[u] = 1'b0;
      if (!ok) post("go_timeout", 32'd0, 32'd1);
      @(negedge clk);
      post("go_to_req_latency", 32'(mem_req_val[u]), 32'd1);
      ok = 0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         if (in_rdy[u]) bad = 1;
         if (done_val[u] && done_rdy[u]) ok = 1;
         else if (done_val[u]) held++;
         cyc();
         if (held >= hold) done_rdy[u] = 1'b1;
         if (!ok) @(negedge clk);
      end
      if (!ok) post("done_timeout", 32'd0, 32'd1);
      post("in_rdy_low_during_wb", 32'(bad), 32'd0);
      if (hold > 0) post("done_hold_cycles", 32'(held), 32'(hold));
      @(negedge clk);
      post("in_rdy_after_done", 32'(in_rdy[u]), 32'd1);
      cyc();
   endtask

   initial begin
      int  req_seen;
      bit  ok;
      for (int u = 0; u < 2; u++) begin
         reset[u] = 1'b1; in_val[u] = 1'b0; in_idx[u] = '0; in_data[u] = '0;
         go_val[u] = 1'b0; go_base[u] = '0; done_rdy[u] = 1'b0;
         stall_en[u] = 1'b0; resp_hold[u] = 1'b0;
      end
      repeat (3) cyc();
      reset[0] = 1'b0; reset[1] = 1'b0;

      // 1: reset values, then immediate go writes zeros
      @(negedge clk);
      post("rst_in_rdy", 32'(in_rdy[0]), 32'd1);
      post("rst_go_rdy", 32'(go_rdy[0]), 32'd1);
      post("rst_mem_req_val", 32'(mem_req_val[0]), 32'd0);
      post("rst_mem_resp_rdy", 32'(mem_resp_rdy[0]), 32'd0);
      post("rst_done_val", 32'(done_val[0]), 32'd0);
      post("rst_done_count", done_count[0], 32'd0);
      post("rst_u1_in_rdy", 32'(in_rdy[1]), 32'd1);
      cyc();
      ea = '{default: 32'd0};
      run_go(0, 8, 32'h0, 32'd0, 0, 1'b0, 3'd0, 32'd0);

      // 2: basic accumulation
      send(0, 3'd2, 32'd5); send(0, 3'd2, 32'd7); send(0, 3'd0, 32'd1);
      ea = '{32'd1, 32'd0, 32'd12, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
      run_go(0, 8, 32'h1000, 32'd3, 0, 1'b0, 3'd0, 32'd0);

      // 3: contribution fires in the same cycle as go
      ea = '{32'd0, 32'd0, 32'd0, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0};
      run_go(0, 8, 32'h1000, 32'd1, 0, 1'b1, 3'd3, 32'd9);

      // 4: wrap-around and top index
      send(0, 3'd1, 32'hFFFF_FFFF); send(0, 3'd1, 32'd2); send(0, 3'd7, 32'd5);
      ea = '{32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd5};
      run_go(0, 8, 32'h0, 32'd3, 0, 1'b0, 3'd0, 32'd0);

      // 5: random memory stalls, completion held off for 5 cycles
      stall_en[0] = 1'b1;
      send(0, 3'd0, 32'd10); send(0, 3'd7, 32'd70); send(0, 3'd3, 32'd33);
      ea = '{32'd10, 32'd0, 32'd0, 32'd33, 32'd0, 32'd0, 32'd0, 32'd70};
      run_go(0, 8, 32'h2000, 32'd3, 5, 1'b0, 3'd0, 32'd0);
      stall_en[0] = 1'b0;

      // 6: reset while waiting for a write response
      send(0, 3'd0, 32'd21); send(0, 3'd4, 32'd44);
      resp_hold[0] = 1'b1;
      push_wr(0, 0, 32'h3000, 32'd21);
      go_val[0] = 1'b1; go_base[0] = 32'h3000;
      cyc();
      go_val[0] = 1'b0;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (mem_resp_rdy[0]) ok = 1;
         cyc();
      end
      post("reached_wresp", 32'(ok), 32'd1);
      do_reset(0);
      resp_hold[0] = 1'b0;
      req_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_req_val[0]) req_seen++;
      end
      post("no_req_after_reset", 32'(req_seen), 32'd0);
      post("post_rst_in_rdy", 32'(in_rdy[0]), 32'd1);
      post("post_rst_done_val", 32'(done_val[0]), 32'd0);
      cyc();
      ea = '{default: 32'd0};
      run_go(0, 8, 32'h3000, 32'd0, 0, 1'b0, 3'd0, 32'd0);

      // 4b: six-node unit drops indices 6 and 7
      send(1, 3'd7, 32'd99); send(1, 3'd6, 32'd3); send(1, 3'd5, 32'd4); send(1, 3'd0, 32'd8);
      ea = '{32'd8, 32'd0, 32'd0, 32'd0, 32'd0, 32'd4, 32'd0, 32'd0};
      run_go(1, 6, 32'h4000, 32'd2, 0, 1'b0, 3'd0, 32'd0);

      repeat (4) @(negedge clk);
      post("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running required finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
